// File: rtl/sdram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sdram_arb_pkg
// Description : Shared state encoding and default sizing for the SDRAM port
//               arbiter (QSPI read port vs. USB write port).
// Revision    : 1.0 - initial release
// ============================================================================
package sdram_arb_pkg;

   // Default sizing: 24-bit word address, 16-bit words, 2-word read bursts
   localparam int c_addr_w_dflt   = 24;
   localparam int c_data_w_dflt   = 16;
   localparam int c_rd_burst_dflt = 2;

   // Arbiter FSM states
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CMD_RD  = 2'd1,
      ST_RD_WAIT = 2'd2,
      ST_CMD_WR  = 2'd3
   } arb_state_t;

endpackage : sdram_arb_pkg
`default_nettype wire

// File: rtl/arb_rdata_fifo.sv
`default_nettype none
// ============================================================================
// Module      : arb_rdata_fifo
// Description : Synchronous first-word-fall-through FIFO buffering read data
//               returned by the SDRAM controller; exposes its fill count.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_rdata_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_push,
   input  logic [WIDTH-1:0]           i_push_data,
   input  logic                       i_pop,
   output logic [WIDTH-1:0]           o_head_data,
   output logic                       o_empty,
   output logic [$clog2(DEPTH+1)-1:0] o_count
);

   localparam int c_cnt_w = $clog2(DEPTH + 1);
   localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [c_cnt_w-1:0] c_depth    = c_cnt_w'(DEPTH);
   localparam logic [c_ptr_w-1:0] c_ptr_last = c_ptr_w'(DEPTH - 1);

   logic [WIDTH-1:0]   r_mem [DEPTH];
   logic [c_ptr_w-1:0] r_wr_ptr;
   logic [c_ptr_w-1:0] r_rd_ptr;
   logic [c_cnt_w-1:0] r_count;
   logic               w_do_push;
   logic               w_do_pop;

   // A push into a full FIFO or a pop from an empty one is ignored
   assign w_do_push = i_push && (r_count != c_depth);
   assign w_do_pop  = i_pop  && (r_count != '0);

   // Storage array: written at the tail, no reset needed
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_push_data;
      end
   end

   // Pointer and occupancy tracking; simultaneous push/pop keeps the count
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= (r_wr_ptr == c_ptr_last) ? '0 : r_wr_ptr + 1'b1;
         end
         if (w_do_pop) begin
            r_rd_ptr <= (r_rd_ptr == c_ptr_last) ? '0 : r_rd_ptr + 1'b1;
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Head word is presented while non-empty, zero otherwise
   assign o_empty     = (r_count == '0);
   assign o_head_data = o_empty ? '0 : r_mem[r_rd_ptr];
   assign o_count     = r_count;

endmodule : arb_rdata_fifo
`default_nettype wire

// File: rtl/sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sdram_port_arbiter
// Description : Two-port arbiter in front of an SDRAM controller. A QSPI read
//               port issues burst reads whose data is buffered in a return
//               FIFO; a USB write port issues single-word writes. Reads have
//               priority, bounded by a starvation counter protecting writes.
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_port_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int ADDR_W      = c_addr_w_dflt,
   parameter int DATA_W      = c_data_w_dflt,
   parameter int RD_BURST    = c_rd_burst_dflt,
   parameter int STARVE_MAX  = 8,
   parameter int RFIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              init_done,
   // QSPI read request
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic              rd_avalid,
   output logic              rd_aready,
   // QSPI read return
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   input  logic              rd_ready,
   // USB write request
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_valid,
   output logic              wr_ready,
   // Controller command
   output logic              m_valid,
   input  logic              m_ready,
   output logic              m_we,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   // Controller return
   input  logic [DATA_W-1:0] m_rdata,
   input  logic              m_rvalid,
   // Status
   output logic              err_unexp_rdata
);

   localparam int c_starve_w = $clog2(STARVE_MAX + 1);
   localparam int c_cnt_w    = $clog2(RFIFO_DEPTH + 1);
   localparam int c_beat_w   = (RD_BURST > 1) ? $clog2(RD_BURST) : 1;

   localparam logic [c_starve_w-1:0] c_starve_max = c_starve_w'(STARVE_MAX);
   localparam logic [c_cnt_w-1:0]    c_rd_limit   = c_cnt_w'(RFIFO_DEPTH - RD_BURST);
   localparam logic [c_beat_w-1:0]   c_beat_last  = c_beat_w'(RD_BURST - 1);

   arb_state_t            r_state;
   logic [c_starve_w-1:0] r_starve_cnt;
   logic [c_beat_w-1:0]   r_beat_cnt;
   logic                  r_m_valid;
   logic                  r_m_we;
   logic [ADDR_W-1:0]     r_m_addr;
   logic [DATA_W-1:0]     r_m_wdata;
   logic                  r_err;

   logic                  w_idle_ok;
   logic                  w_rd_elig;
   logic                  w_starved;
   logic                  w_grant_rd;
   logic                  w_grant_wr;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_fifo_empty;
   logic [DATA_W-1:0]     w_fifo_head;
   logic [c_cnt_w-1:0]    w_fifo_count;

   // A read may only start when a whole burst is guaranteed to fit in the
   // FIFO, so the controller return path never needs backpressure.
   assign w_idle_ok  = (r_state == ST_IDLE) && init_done && !rst;
   assign w_rd_elig  = rd_avalid && (w_fifo_count <= c_rd_limit);
   assign w_starved  = wr_valid && (r_starve_cnt == c_starve_max);
   assign w_grant_rd = w_idle_ok && w_rd_elig && !w_starved;
   assign w_grant_wr = w_idle_ok && wr_valid && !w_grant_rd;

   assign w_push = m_rvalid && (r_state == ST_RD_WAIT);
   assign w_pop  = rd_valid && rd_ready;

   // Command FSM: grants in IDLE, holds the command until accepted, then
   // collects the read burst before returning to IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_beat_cnt <= '0;
         r_m_valid  <= 1'b0;
         r_m_we     <= 1'b0;
         r_m_addr   <= '0;
         r_m_wdata  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_grant_rd) begin
                  r_m_valid <= 1'b1;
                  r_m_we    <= 1'b0;
                  r_m_addr  <= rd_addr;
                  r_m_wdata <= '0;
                  r_state   <= ST_CMD_RD;
               end else if (w_grant_wr) begin
                  r_m_valid <= 1'b1;
                  r_m_we    <= 1'b1;
                  r_m_addr  <= wr_addr;
                  r_m_wdata <= wr_data;
                  r_state   <= ST_CMD_WR;
               end
            end
            ST_CMD_RD: begin
               if (m_ready) begin
                  r_m_valid  <= 1'b0;
                  r_beat_cnt <= '0;
                  r_state    <= ST_RD_WAIT;
               end
            end
            ST_RD_WAIT: begin
               if (m_rvalid) begin
                  if (r_beat_cnt == c_beat_last) begin
                     r_beat_cnt <= '0;
                     r_state    <= ST_IDLE;
                  end else begin
                     r_beat_cnt <= r_beat_cnt + 1'b1;
                  end
               end
            end
            ST_CMD_WR: begin
               if (m_ready) begin
                  r_m_valid <= 1'b0;
                  r_state   <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Counts read grants taken while a write waits; saturates at the limit
   always_ff @(posedge clk) begin
      if (rst) begin
         r_starve_cnt <= '0;
      end else if (!wr_valid || w_grant_wr) begin
         r_starve_cnt <= '0;
      end else if (w_grant_rd && (r_starve_cnt != c_starve_max)) begin
         r_starve_cnt <= r_starve_cnt + 1'b1;
      end
   end

   // Sticky flag for return data arriving when no burst is outstanding
   always_ff @(posedge clk) begin
      if (rst) begin
         r_err <= 1'b0;
      end else if (m_rvalid && (r_state != ST_RD_WAIT)) begin
         r_err <= 1'b1;
      end
   end

   arb_rdata_fifo #(
      .DEPTH (RFIFO_DEPTH),
      .WIDTH (DATA_W)
   ) u_rdata_fifo (
      .clk         (clk),
      .rst         (rst),
      .i_push      (w_push),
      .i_push_data (m_rdata),
      .i_pop       (w_pop),
      .o_head_data (w_fifo_head),
      .o_empty     (w_fifo_empty),
      .o_count     (w_fifo_count)
   );

   assign rd_aready       = w_grant_rd;
   assign wr_ready        = w_grant_wr;
   assign rd_valid        = !w_fifo_empty && !rst;
   assign rd_data         = rst ? '0 : w_fifo_head;
   assign m_valid         = r_m_valid;
   assign m_we            = r_m_we;
   assign m_addr          = r_m_addr;
   assign m_wdata         = r_m_wdata;
   assign err_unexp_rdata = r_err;

endmodule : sdram_port_arbiter
`default_nettype wire

// File: tb/tb_sdram_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_sdram_port_arbiter
// Description : Scoreboard bench for sdram_port_arbiter: directed scenarios
//               followed by randomized traffic against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_port_arbiter;

   localparam int ADDR_W      = 24;
   localparam int DATA_W      = 16;
   localparam int RD_BURST    = 2;
   localparam int STARVE_MAX  = 8;
   localparam int RFIFO_DEPTH = 4;

   localparam int S_VALUE = 0, S_RD_AREADY = 1, S_WR_READY = 2, S_M_VALID = 3,
                  S_M_WE = 4, S_M_ADDR = 5, S_M_WDATA = 6, S_RD_VALID = 7,
                  S_RD_DATA = 8, S_ERR = 9, S_QEMPTY = 10;

   typedef struct {
      int          sig;
      logic [63:0] act;
      logic [63:0] val;
      string       name;
   } dexp_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              init_done;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_avalid;
   logic              rd_aready;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic              rd_ready;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              wr_valid;
   logic              wr_ready;
   logic              m_valid;
   logic              m_ready;
   logic              m_we;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_wdata;
   logic [DATA_W-1:0] m_rdata;
   logic              m_rvalid;
   logic              err_unexp_rdata;

   // Scoreboard queues: stimulus side pushes, monitor pops
   logic [ADDR_W-1:0]        exp_rd_cmd [$];
   logic [ADDR_W+DATA_W-1:0] exp_wr_cmd [$];
   logic [DATA_W-1:0]        exp_rdata  [$];
   dexp_t                    dexp_q     [$];

   int vectors    = 0;
   int miscompares = 0;

   // Stimulus-side bookkeeping
   int n_rd = 0, n_wr = 0, n_pop = 0;
   bit last_rd = 0, last_wr = 0;
   int drive_left = 0;
   bit auto_ctrl = 0;
   int mready_pct = 100;

   // Reference model state (monitor only)
   bit busy = 0;
   int beats = 0;
   int occ = 0;
   int starve = 0;
   bit pend_cmd = 0;
   bit pend_we = 0;

   always #5 clk = ~clk;

   sdram_port_arbiter #(
      .ADDR_W      (ADDR_W),
      .DATA_W      (DATA_W),
      .RD_BURST    (RD_BURST),
      .STARVE_MAX  (STARVE_MAX),
      .RFIFO_DEPTH (RFIFO_DEPTH)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .init_done       (init_done),
      .rd_addr         (rd_addr),
      .rd_avalid       (rd_avalid),
      .rd_aready       (rd_aready),
      .rd_data         (rd_data),
      .rd_valid        (rd_valid),
      .rd_ready        (rd_ready),
      .wr_addr         (wr_addr),
      .wr_data         (wr_data),
      .wr_valid        (wr_valid),
      .wr_ready        (wr_ready),
      .m_valid         (m_valid),
      .m_ready         (m_ready),
      .m_we            (m_we),
      .m_addr          (m_addr),
      .m_wdata         (m_wdata),
      .m_rdata         (m_rdata),
      .m_rvalid        (m_rvalid),
      .err_unexp_rdata (err_unexp_rdata)
   );

   task automatic chk(input bit ok, input string name,
                      input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (!ok) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] sample(input int sig, input logic [63:0] given);
      case (sig)
         S_RD_AREADY: return 64'(rd_aready);
         S_WR_READY:  return 64'(wr_ready);
         S_M_VALID:   return 64'(m_valid);
         S_M_WE:      return 64'(m_we);
         S_M_ADDR:    return 64'(m_addr);
         S_M_WDATA:   return 64'(m_wdata);
         S_RD_VALID:  return 64'(rd_valid);
         S_RD_DATA:   return 64'(rd_data);
         S_ERR:       return 64'(err_unexp_rdata);
         S_QEMPTY:    return 64'(exp_rd_cmd.size() + exp_wr_cmd.size() + exp_rdata.size());
         default:     return given;
      endcase
   endfunction

   // Monitor: directed expectations plus reference-model checks every cycle
   always @(negedge clk) begin
      bit g_rd, g_wr, e_rd, e_wr, rd_elig;
      logic [63:0] a;
      dexp_t d;
      logic [ADDR_W-1:0] ea;
      logic [ADDR_W+DATA_W-1:0] ew;
      logic [DATA_W-1:0] ed;

      while (dexp_q.size() > 0) begin
         d = dexp_q.pop_front();
         a = sample(d.sig, d.act);
         chk(a === d.val, d.name, a, d.val);
      end

      if (rst) begin
         busy = 0; beats = 0; occ = 0; starve = 0; pend_cmd = 0; pend_we = 0;
         exp_rd_cmd.delete(); exp_wr_cmd.delete(); exp_rdata.delete();
      end else begin
         g_rd    = rd_avalid && rd_aready;
         g_wr    = wr_valid && wr_ready;
         rd_elig = rd_avalid && (occ + RD_BURST <= RFIFO_DEPTH);
         e_rd    = !busy && init_done && rd_elig && !(wr_valid && starve == STARVE_MAX);
         e_wr    = !busy && init_done && wr_valid && !e_rd;
         chk(g_rd == e_rd, "read grant", 64'(g_rd), 64'(e_rd));
         chk(g_wr == e_wr, "write grant", 64'(g_wr), 64'(e_wr));

         if (pend_cmd)
            chk(m_valid && (m_we == pend_we), "command issue", {62'd0, m_valid, m_we},
                {62'd0, 1'b1, pend_we});
         pend_cmd = g_rd || g_wr;
         pend_we  = g_wr;

         chk(rd_valid == (occ > 0), "rd_valid vs occupancy", 64'(rd_valid), 64'(occ));

         if (m_valid && m_ready) begin
            if (m_we) begin
               if (exp_wr_cmd.size() == 0) chk(1'b0, "unexpected write cmd", 64'(m_addr), 64'd0);
               else begin
                  ew = exp_wr_cmd.pop_front();
                  chk({m_addr, m_wdata} == ew, "write cmd addr/data",
                      64'({m_addr, m_wdata}), 64'(ew));
               end
               busy = 0;
            end else begin
               if (exp_rd_cmd.size() == 0) chk(1'b0, "unexpected read cmd", 64'(m_addr), 64'd0);
               else begin
                  ea = exp_rd_cmd.pop_front();
                  chk(m_addr == ea, "read cmd addr", 64'(m_addr), 64'(ea));
               end
               beats = RD_BURST;
            end
         end

         if (m_rvalid && beats > 0) begin
            beats--;
            occ++;
            if (beats == 0) busy = 0;
         end

         if (rd_valid && rd_ready) begin
            if (exp_rdata.size() == 0) chk(1'b0, "unexpected read data", 64'(rd_data), 64'd0);
            else begin
               ed = exp_rdata.pop_front();
               chk(rd_data == ed, "read data", 64'(rd_data), 64'(ed));
            end
            if (occ > 0) occ--;
         end

         if (g_rd || g_wr) busy = 1;

         if (!wr_valid || g_wr) starve = 0;
         else if (g_rd && starve < STARVE_MAX) starve++;
      end
   end

   task automatic expect_sig(input int sig, input logic [63:0] val, input string name);
      dexp_q.push_back('{sig, 64'd0, val, name});
   endtask

   task automatic expect_val(input logic [63:0] act, input logic [63:0] val, input string name);
      dexp_q.push_back('{S_VALUE, act, val, name});
   endtask

   // One clock: record grants at negedge, then update controller drive
   task automatic step();
      @(negedge clk);
      last_rd = 0;
      last_wr = 0;
      if (!rst) begin
         if (rd_avalid && rd_aready) begin
            exp_rd_cmd.push_back(rd_addr); n_rd++; last_rd = 1;
         end
         if (wr_valid && wr_ready) begin
            exp_wr_cmd.push_back({wr_addr, wr_data}); n_wr++; last_wr = 1;
         end
         if (m_valid && m_ready && !m_we) drive_left = RD_BURST;
         if (rd_valid && rd_ready) n_pop++;
      end
      @(posedge clk);
      #1;
      if (auto_ctrl) begin
         m_ready = ($urandom_range(99) < mready_pct);
         if (drive_left > 0 && $urandom_range(3) != 0) begin
            m_rvalid = 1'b1;
            m_rdata  = DATA_W'($urandom);
            exp_rdata.push_back(m_rdata);
            drive_left--;
         end else begin
            m_rvalid = 1'b0;
         end
      end
   endtask

   task automatic ret_word(input logic [DATA_W-1:0] d);
      m_rvalid = 1'b1;
      m_rdata  = d;
      exp_rdata.push_back(d);
      if (drive_left > 0) drive_left--;
   endtask

   task automatic do_reset();
      rst = 1'b1; rd_avalid = 1'b0; wr_valid = 1'b0; m_rvalid = 1'b0; drive_left = 0;
      step();
      expect_sig(S_M_VALID, 0, "reset m_valid");
      expect_sig(S_M_WE, 0, "reset m_we");
      expect_sig(S_M_ADDR, 0, "reset m_addr");
      expect_sig(S_M_WDATA, 0, "reset m_wdata");
      expect_sig(S_RD_AREADY, 0, "reset rd_aready");
      expect_sig(S_WR_READY, 0, "reset wr_ready");
      expect_sig(S_RD_VALID, 0, "reset rd_valid");
      expect_sig(S_RD_DATA, 0, "reset rd_data");
      expect_sig(S_ERR, 0, "reset err_unexp_rdata");
      step();
      rst = 1'b0;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         step();
         if (last_rd) rd_addr = ADDR_W'($urandom);
      end
   endtask

   initial begin
      int n0, p0, w0;
      bit got;
      rst = 1'b1; init_done = 1'b1; rd_addr = '0; rd_avalid = 1'b0; rd_ready = 1'b1;
      wr_addr = '0; wr_data = '0; wr_valid = 1'b0; m_ready = 1'b1; m_rdata = '0;
      m_rvalid = 1'b0;

      do_reset();

      // Single read with fixed return data
      auto_ctrl = 0; m_ready = 1'b1; rd_ready = 1'b1;
      rd_addr = 24'h000010; rd_avalid = 1'b1;
      expect_sig(S_RD_AREADY, 1, "single read grant");
      step();
      rd_avalid = 1'b0;
      expect_sig(S_M_VALID, 1, "single read m_valid");
      expect_sig(S_M_WE, 0, "single read m_we");
      expect_sig(S_M_ADDR, 64'h10, "single read m_addr");
      step();
      ret_word(16'hA5A5);
      step();
      ret_word(16'h5A5A);
      expect_sig(S_RD_DATA, 64'hA5A5, "single read word0");
      step();
      m_rvalid = 1'b0;
      expect_sig(S_RD_DATA, 64'h5A5A, "single read word1");
      step();
      step();

      // Single write held under controller backpressure
      m_ready = 1'b0; wr_addr = 24'h001234; wr_data = 16'hBEEF; wr_valid = 1'b1;
      expect_sig(S_WR_READY, 1, "single write grant");
      step();
      wr_valid = 1'b0;
      expect_sig(S_M_VALID, 1, "write m_valid");
      expect_sig(S_M_WE, 1, "write m_we");
      expect_sig(S_M_ADDR, 64'h1234, "write m_addr");
      expect_sig(S_M_WDATA, 64'hBEEF, "write m_wdata");
      step();
      expect_sig(S_M_VALID, 1, "write m_valid held");
      expect_sig(S_M_WDATA, 64'hBEEF, "write m_wdata held");
      step();
      m_ready = 1'b1;
      step();
      expect_sig(S_M_VALID, 0, "write m_valid dropped");
      step();

      // Starvation: both ports requesting continuously
      auto_ctrl = 1; mready_pct = 100; rd_ready = 1'b1;
      rd_addr = ADDR_W'($urandom); rd_avalid = 1'b1;
      for (int k = 0; k < 2; k++) begin
         wr_addr = ADDR_W'($urandom); wr_data = DATA_W'($urandom); wr_valid = 1'b1;
         n0 = n_rd; w0 = n_wr; got = 0;
         for (int i = 0; i < 400 && !got; i++) begin
            step();
            if (last_rd) rd_addr = ADDR_W'($urandom);
            if (last_wr) got = 1;
         end
         expect_val(64'(got), 1, "starved write granted");
         expect_val(64'(n_rd - n0), STARVE_MAX, "reads before starved write");
      end
      rd_avalid = 1'b0; wr_valid = 1'b0;
      run(30);

      // Backpressure: FIFO fills with two bursts
      rd_ready = 1'b0; rd_avalid = 1'b1; rd_addr = ADDR_W'($urandom);
      n0 = n_rd;
      run(40);
      expect_val(64'(n_rd - n0), 2, "reads granted with FIFO blocked");
      rd_ready = 1'b1;
      step();
      rd_ready = 1'b0;
      run(10);
      expect_val(64'(n_rd - n0), 2, "no grant after one pop");
      rd_ready = 1'b1;
      step();
      rd_ready = 1'b0;
      for (int i = 0; i < 20 && (n_rd - n0) < 3; i++) run(1);
      rd_avalid = 1'b0;
      expect_val(64'(n_rd - n0), 3, "third read after two pops");
      rd_ready = 1'b1;
      run(30);

      // Gating by init_done and unexpected return data
      init_done = 1'b0; rd_avalid = 1'b1; wr_valid = 1'b1;
      n0 = n_rd + n_wr;
      run(10);
      expect_val(64'(n_rd + n_wr - n0), 0, "grants while init_done low");
      rd_avalid = 1'b0; wr_valid = 1'b0;
      auto_ctrl = 0;
      m_rvalid = 1'b1; m_rdata = 16'hDEAD;
      step();
      m_rvalid = 1'b0;
      expect_sig(S_ERR, 1, "err_unexp_rdata set");
      expect_sig(S_RD_VALID, 0, "stray data not buffered");
      step();
      init_done = 1'b1;

      // Reset in the middle of a read burst
      m_ready = 1'b1; rd_ready = 1'b0; rd_addr = 24'h000040; rd_avalid = 1'b1;
      step();
      rd_avalid = 1'b0;
      step();
      ret_word(16'h1111);
      step();
      m_rvalid = 1'b0;
      do_reset();
      auto_ctrl = 1; mready_pct = 100; rd_ready = 1'b1;
      rd_addr = 24'h000080; rd_avalid = 1'b1;
      p0 = n_pop;
      step();
      rd_avalid = 1'b0;
      run(30);
      expect_val(64'(n_pop - p0), RD_BURST, "read after reset returns burst");

      // Randomized traffic
      mready_pct = 70;
      n0 = n_rd; w0 = n_wr;
      for (int i = 0; i < 3000; i++) begin
         step();
         if (last_rd || !rd_avalid) begin
            rd_avalid = ($urandom_range(99) < 60);
            rd_addr   = ADDR_W'($urandom);
         end
         if (last_wr || !wr_valid) begin
            wr_valid = ($urandom_range(99) < 40);
            wr_addr  = ADDR_W'($urandom);
            wr_data  = DATA_W'($urandom);
         end
         rd_ready  = ($urandom_range(99) < 70);
         init_done = ($urandom_range(99) != 0);
      end
      rd_avalid = 1'b0; wr_valid = 1'b0; init_done = 1'b1; rd_ready = 1'b1;
      mready_pct = 100;
      run(40);
      expect_sig(S_QEMPTY, 0, "scoreboard drained");
      expect_val(64'((n_rd > n0) && (n_wr > w0)), 1, "random traffic granted");
      step();
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_sdram_port_arbiter
`default_nettype wire

// File: doc/sdram_port_arbiter.md
SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

Interface
REQ-001 Parameters (name, default, meaning): ADDR_W, 24, word address width; DATA_W, 16, data width; RD_BURST, 2, words returned per read command (one 4-byte QSPI fast-read burst); STARVE_MAX, 8, consecutive read grants tolerated while a write waits; RFIFO_DEPTH, 4, read-return buffer depth in words.
REQ-002 Ports (name, direction, width, meaning): clk, in, 1, single clock, SDRAM domain; rst, in, 1, reset, synchronous and active-high.
REQ-003 init_done, in, 1: SDRAM controller initialisation complete; no grants while low.
REQ-004 Read request (QSPI side): rd_addr, in, ADDR_W; rd_avalid, in, 1; rd_aready, out, 1.
REQ-005 Read return: rd_data, out, DATA_W; rd_valid, out, 1; rd_ready, in, 1.
REQ-006 Write request (USB side): wr_addr, in, ADDR_W; wr_data, in, DATA_W; wr_valid, in, 1; wr_ready, out, 1.
REQ-007 Controller command: m_valid, out, 1; m_ready, in, 1; m_we, out, 1 (1 = write); m_addr, out, ADDR_W; m_wdata, out, DATA_W.
REQ-008 Controller return: m_rdata, in, DATA_W; m_rvalid, in, 1 (no backpressure).
REQ-009 err_unexp_rdata, out, 1: sticky flag, set on m_rvalid outside RD_WAIT.

Function
REQ-010 FSM states: IDLE, CMD_RD, RD_WAIT, CMD_WR.
REQ-011 IDLE with init_done=0: no grant; rd_aready=wr_ready=0.
REQ-012 Read eligible in IDLE when rd_avalid=1 and free FIFO entries >= RD_BURST.
REQ-013 Arbitration in IDLE: read wins unless wr_valid=1 and starve_cnt==STARVE_MAX; write granted whenever read not eligible and wr_valid=1.
REQ-014 Grant is combinational in IDLE: rd_aready or wr_ready high for exactly that cycle; addr/data captured into command register; next state CMD_RD or CMD_WR.
REQ-015 CMD_RD/CMD_WR: m_valid=1 from cycle after grant, m_addr/m_we/m_wdata stable until m_valid&m_ready; request-to-m_valid latency is 1 cycle.
REQ-016 CMD_RD on handshake -> RD_WAIT; CMD_WR on handshake -> IDLE.
REQ-017 RD_WAIT: each m_rvalid pushes m_rdata into FIFO; after RD_BURST words -> IDLE; same-cycle new grant not permitted (one IDLE cycle minimum between commands).
REQ-018 starve_cnt (width clog2(STARVE_MAX+1)): +1 on read grant while wr_valid=1; cleared on write grant or any cycle wr_valid=0; saturates at STARVE_MAX.
REQ-019 Read-return FIFO: rd_valid = not empty, rd_data = head word (first-word fall-through); pop on rd_valid&rd_ready; simultaneous push and pop permitted, count unchanged.
REQ-020 FIFO overflow impossible by REQ-012; FIFO full with rd_ready=0 only blocks new read grants, never drops data.
REQ-021 m_rvalid in any state other than RD_WAIT: data discarded, err_unexp_rdata set until rst.
REQ-022 init_done falling mid-command: current command and burst complete normally; no further grants.

Reset
REQ-023 rst=1 at a clk edge: state IDLE, starve_cnt=0, FIFO emptied, command register cleared.
REQ-024 Output values during/after reset: m_valid=0, m_we=0, m_addr=0, m_wdata=0, rd_aready=0, wr_ready=0, rd_valid=0, rd_data=0, err_unexp_rdata=0.
REQ-025 Reset mid-burst abandons the command; controller shares the same reset, so no residual return data is expected.

Structure
REQ-026 Shared package sdram_arb_pkg holds state encoding and default values of ADDR_W, DATA_W, RD_BURST.
REQ-027 Read-return FIFO is sub-module arb_rdata_fifo (sync, parameterised depth/width, count output); FSM and starvation counter stay in sdram_port_arbiter.

Verification
REQ-028 Single read: init_done=1, rd_addr=0x000010 valid, m_ready=1, return 0xA5A5,0x5A5A -> rd_aready at cycle 0, m_valid/m_we=0 at cycle 1, rd_data 0xA5A5 then 0x5A5A.
REQ-029 Single write: wr_addr=0x001234, wr_data=0xBEEF -> wr_ready one cycle, m_we=1, m_addr=0x001234, m_wdata=0xBEEF held until m_ready.
REQ-030 Starvation: rd_avalid and wr_valid held high -> exactly 8 read grants, then 1 write grant, starve_cnt returns to 0.
REQ-031 Backpressure: rd_ready=0, 3 reads requested -> 2 reads granted (FIFO 4/4), third granted only after 2 pops.
REQ-032 Gating/errors: init_done=0 with requests -> no grants; m_rvalid pulse in IDLE -> err_unexp_rdata=1, FIFO count unchanged.
REQ-033 Reset mid-burst: rst after first return word -> all outputs at REQ-024 values next cycle, FIFO empty, next read works.
